maze_dfs_ctrl: RTL and testbench

//  Depth-first maze-walk controller that drives the location-step datapath.
//  It issues a direction and the current location, consumes the datapath's next

---
 rtl/maze_dfs_ctrl_pkg.sv | 31 +++
 rtl/maze_dfs_ctrl_path_stack.sv | 59 +++++
 rtl/maze_dfs_ctrl.sv | 129 ++++++++++++
 tb/tb_maze_dfs_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_dfs_ctrl_pkg.sv
// Shared types and constants for the depth-first maze-walk controller.
// Locations are {x[3:0], y[3:0]} on a 16x16 grid.
package maze_dfs_ctrl_pkg;

  localparam int LOC_W = 8;
  localparam int TRY_W = 3;
  localparam int SP_W  = 9;

  localparam logic [TRY_W-1:0] TRY_EXHAUSTED = 3'd4;

  localparam logic [1:0] DIR_YM = 2'b00;
  localparam logic [1:0] DIR_XP = 2'b01;
  localparam logic [1:0] DIR_XM = 2'b10;
  localparam logic [1:0] DIR_YP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CHECK,
    ST_POP,
    ST_DONE,
    ST_FAIL
  } state_e;

  // One backtrack record: the cell we left and the next direction to try there.
  typedef struct packed {
    logic [LOC_W-1:0] loc;
    logic [TRY_W-1:0] tryDir;
  } stackEntry_t;

endpackage

// File: rtl/maze_dfs_ctrl_path_stack.sv
// Backtrack path stack: synchronous push/pop, registered pointer,
// combinational top-of-stack and full/empty flags.
module maze_dfs_ctrl_path_stack
  import maze_dfs_ctrl_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  stackEntry_t     pushData_i,
  output stackEntry_t     top_o,
  output logic [SP_W-1:0] sp_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stackEntry_t     mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_d;
  logic [AW-1:0]   topIdx;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;
  assign topIdx  = sp_q[AW-1:0] - AW'(1);
  assign top_o   = mem_q[topIdx];

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage carries no reset; only entries below the pointer are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !clear_i) begin
      mem_q[sp_q[AW-1:0]] <= pushData_i;
    end
  end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze-walk controller: walks the location-step datapath one
// direction per cycle, tracking visited cells and a backtrack stack.
module maze_dfs_ctrl
  import maze_dfs_ctrl_pkg::*;
#(
  parameter logic [LOC_W-1:0] START_LOC   = 8'h00,
  parameter logic [LOC_W-1:0] GOAL_LOC    = 8'hFF,
  parameter int               STACK_DEPTH = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LOC_W-1:0] nxtLoc_i,
  input  logic             cntReach_i,
  input  logic             memWall_i,
  output logic [1:0]       dir_o,
  output logic [LOC_W-1:0] currLoc_o,
  output logic             rgLd_o,
  output logic [LOC_W-1:0] memAddr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [SP_W-1:0]  pathLen_o
);

  state_e           state_q, state_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [LOC_W-1:0] currLoc_q, currLoc_d;
  logic [255:0]     visited_q;

  logic        visitInit, visitMark, blocked;
  logic        stkClear, stkPush, stkPop, stkFull, stkEmpty;
  stackEntry_t stkPushData, stkTop;
  logic [SP_W-1:0] stkSp;

  maze_dfs_ctrl_path_stack #(
    .DEPTH (STACK_DEPTH)
  ) uStack (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (stkClear),
    .push_i     (stkPush),
    .pop_i      (stkPop),
    .pushData_i (stkPushData),
    .top_o      (stkTop),
    .sp_o       (stkSp),
    .full_o     (stkFull),
    .empty_o    (stkEmpty)
  );

  assign blocked     = cntReach_i | memWall_i | visited_q[nxtLoc_i];
  assign stkPushData = '{loc: currLoc_q, tryDir: try_q + TRY_W'(1)};

  always_comb begin
    state_d   = state_q;
    try_d     = try_q;
    currLoc_d = currLoc_q;
    stkClear  = 1'b0;
    stkPush   = 1'b0;
    stkPop    = 1'b0;
    rgLd_o    = 1'b0;
    visitInit = 1'b0;
    visitMark = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_i) state_d = ST_INIT;
      end
      ST_INIT: begin
        stkClear  = 1'b1;
        visitInit = 1'b1;
        currLoc_d = START_LOC;
        try_d     = '0;
        state_d   = (START_LOC == GOAL_LOC) ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        // The exhausted check comes first: dir wraps to 0 when try is 4.
        if (try_q == TRY_EXHAUSTED) begin
          state_d = stkEmpty ? ST_FAIL : ST_POP;
        end else if (blocked) begin
          try_d = try_q + TRY_W'(1);
        end else if (stkFull) begin
          state_d = ST_FAIL;
        end else begin
          stkPush   = 1'b1;
          visitMark = 1'b1;
          rgLd_o    = 1'b1;
          currLoc_d = nxtLoc_i;
          try_d     = '0;
          state_d   = (nxtLoc_i == GOAL_LOC) ? ST_DONE : ST_CHECK;
        end
      end
      ST_POP: begin
        stkPop    = 1'b1;
        currLoc_d = stkTop.loc;
        try_d     = stkTop.tryDir;
        state_d   = ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      try_q     <= '0;
      currLoc_q <= START_LOC;
      visited_q <= '0;
    end else begin
      state_q   <= state_d;
      try_q     <= try_d;
      currLoc_q <= currLoc_d;
      if (visitInit) begin
        visited_q            <= '0;
        visited_q[START_LOC] <= 1'b1;
      end else if (visitMark) begin
        visited_q[nxtLoc_i] <= 1'b1;
      end
    end
  end

  assign dir_o     = try_q[1:0];
  assign currLoc_o = currLoc_q;
  assign memAddr_o = nxtLoc_i;
  assign busy_o    = (state_q == ST_INIT) || (state_q == ST_CHECK) || (state_q == ST_POP);
  assign done_o    = (state_q == ST_DONE);
  assign fail_o    = (state_q == ST_FAIL);
  assign pathLen_o = stkSp;

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Testbench for maze_dfs_ctrl: models the step datapath and maze memory,
// and checks each solve against a behavioural depth-first search.
module tb_maze_dfs_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] nxtLoc;
  logic       cntReach;
  logic       memWall;
  logic [1:0] dir;
  logic [7:0] currLoc;
  logic       rgLd;
  logic [7:0] memAddr;
  logic       busy;
  logic       done;
  logic       fail;
  logic [8:0] pathLen;

  bit         wallMem [256];
  logic [7:0] expMoves [$];
  int         expCycles;
  int         expLen;
  bit         expDone;
  bit         expFail;
  int         testsRun = 0;
  int         failCount = 0;

  always #5 clk = ~clk;

  maze_dfs_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .nxtLoc_i   (nxtLoc),
    .cntReach_i (cntReach),
    .memWall_i  (memWall),
    .dir_o      (dir),
    .currLoc_o  (currLoc),
    .rgLd_o     (rgLd),
    .memAddr_o  (memAddr),
    .busy_o     (busy),
    .done_o     (done),
    .fail_o     (fail),
    .pathLen_o  (pathLen)
  );

  // Returns {offGrid, neighbour} for one step in direction d.
  function automatic logic [8:0] stepLoc(input logic [7:0] loc, input logic [1:0] d);
    int x, y;
    logic [3:0] xs, ys;
    x = int'(loc[7:4]);
    y = int'(loc[3:0]);
    case (d)
      2'd0: y = y - 1;
      2'd1: x = x + 1;
      2'd2: x = x - 1;
      default: y = y + 1;
    endcase
    xs = x[3:0];
    ys = y[3:0];
    return {(x < 0) || (x > 15) || (y < 0) || (y > 15), xs, ys};
  endfunction

  function automatic int manhattan(input logic [7:0] a, input logic [7:0] b);
    int dx, dy;
    dx = int'(a[7:4]) - int'(b[7:4]);
    dy = int'(a[3:0]) - int'(b[3:0]);
    return (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
  endfunction

  logic [8:0] stepRes;
  always_comb stepRes = stepLoc(currLoc, dir);
  assign nxtLoc   = stepRes[7:0];
  assign cntReach = stepRes[8];
  assign memWall  = wallMem[memAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // kind 0: open grid; 1: start boxed in; 2: dead end at 10; 3: random walls
  task automatic applyStimulus(input int kind);
    for (int i = 0; i < 256; i++) begin
      wallMem[i] = (kind == 3) ? ($urandom_range(0, 99) < 22) : 1'b0;
    end
    if (kind == 1) begin
      wallMem[8'h10] = 1'b1;
      wallMem[8'h01] = 1'b1;
    end
    if (kind == 2) begin
      wallMem[8'h20] = 1'b1;
      wallMem[8'h11] = 1'b1;
    end
    wallMem[8'h00] = 1'b0;
  endtask

  // Reference search from 00 to FF: one counted cycle for INIT, each
  // direction probe and each backtrack.
  task automatic modelSolve();
    bit         vis [256];
    logic [7:0] stLoc [$];
    int         stTry [$];
    logic [7:0] cur;
    logic [8:0] s;
    int         tr;
    expMoves.delete();
    for (int i = 0; i < 256; i++) vis[i] = 1'b0;
    cur = 8'h00;
    vis[0] = 1'b1;
    tr = 0;
    expCycles = 1;
    expDone = 1'b0;
    expFail = 1'b0;
    while (expCycles < 5000) begin
      expCycles++;
      if (tr == 4) begin
        if (stLoc.size() == 0) begin
          expFail = 1'b1;
          break;
        end
        expCycles++;
        cur = stLoc.pop_back();
        tr = stTry.pop_back();
        continue;
      end
      s = stepLoc(cur, 2'(tr));
      if (s[8] || wallMem[s[7:0]] || vis[s[7:0]]) begin
        tr++;
      end else begin
        stLoc.push_back(cur);
        stTry.push_back(tr + 1);
        cur = s[7:0];
        vis[cur] = 1'b1;
        tr = 0;
        expMoves.push_back(cur);
        if (cur == 8'hFF) begin
          expDone = 1'b1;
          break;
        end
      end
    end
    expLen = stLoc.size();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_currLoc"}, 32'(currLoc), 32'h00);
    checkOutput({tag, "_dir"}, 32'(dir), 32'h0);
    checkOutput({tag, "_rgLd"}, 32'(rgLd), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_fail"}, 32'(fail), 32'h0);
    checkOutput({tag, "_pathLen"}, 32'(pathLen), 32'h0);
  endtask

  // Entered with the DUT about to be in INIT at the next falling edge.
  task automatic monitorSolve(input string tag, input bit poke, input bit hold);
    int cnt = 0;
    int idx = 0;
    int bad = 0;
    bit finished = 1'b0;
    bit first = 1'b1;
    while (cnt < 6000) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (first) begin
        checkOutput({tag, "_initBusy"}, 32'(busy), 32'h1);
        checkOutput({tag, "_initDone"}, 32'(done), 32'h0);
        first = 1'b0;
      end
      if (done || fail) begin
        finished = 1'b1;
        break;
      end
      cnt++;
      if (poke && cnt == 6) start = 1'b1;
      if (rgLd) begin
        if (cntReach || memWall || memAddr !== nxtLoc) bad++;
        if (manhattan(memAddr, currLoc) != 1) bad++;
        if (idx >= expMoves.size()) bad++;
        else if (memAddr !== expMoves[idx]) bad++;
        idx++;
      end
    end
    checkOutput({tag, "_finished"}, 32'(finished), 32'h1);
    checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
    checkOutput({tag, "_fail"}, 32'(fail), 32'(expFail));
    checkOutput({tag, "_pathLen"}, 32'(pathLen), 32'(expLen));
    checkOutput({tag, "_cycles"}, 32'(cnt), 32'(expCycles));
    checkOutput({tag, "_moveCount"}, 32'(idx), 32'(expMoves.size()));
    checkOutput({tag, "_badMoves"}, 32'(bad), 32'h0);
  endtask

  task automatic runSolve(input string tag, input bit poke, input bit hold);
    modelSolve();
    @(negedge clk);
    start = 1'b1;
    monitorSolve(tag, poke, hold);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    applyStimulus(0);
    #12;
    checkReset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkReset("idle");

    applyStimulus(0);
    runSolve("t1", 1'b0, 1'b0);
    checkOutput("t1_lenGe30", 32'(pathLen >= 9'd30), 32'h1);

    applyStimulus(1);
    runSolve("t2", 1'b0, 1'b0);
    checkOutput("t2_failFlag", 32'(fail), 32'h1);
    checkOutput("t2_len0", 32'(pathLen), 32'h0);

    applyStimulus(2);
    runSolve("t3", 1'b0, 1'b0);
    checkOutput("t3_doneFlag", 32'(done), 32'h1);

    // First probe from 00 goes off the top edge and must not move.
    applyStimulus(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("t4_dir0", 32'(dir), 32'h0);
    checkOutput("t4_reach", 32'(cntReach), 32'h1);
    checkOutput("t4_noLoad", 32'(rgLd), 32'h0);
    @(negedge clk);
    checkOutput("t4_dir1", 32'(dir), 32'h1);
    checkOutput("t4_load", 32'(rgLd), 32'h1);
    checkOutput("t4_addr", 32'(memAddr), 32'h10);

    // Asynchronous reset in the middle of a walk.
    repeat (10) @(negedge clk);
    checkOutput("t5_moved", 32'(currLoc != 8'h00), 32'h1);
    #2 rst_n = 1'b0;
    #1 checkReset("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    runSolve("t5_rerun", 1'b0, 1'b0);

    applyStimulus(0);
    runSolve("t6_hold", 1'b0, 1'b1);
    monitorSolve("t6_again", 1'b0, 1'b0);
    runSolve("t6_poke", 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      applyStimulus(3);
      runSolve($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
